// File: rtl/fp_int_mac_pkg.sv
// rtl/fp_int_mac_pkg.sv - shared widths and serializer state encoding for the fp_int_mac datapath
package fp_int_mac_pkg;

    localparam int DEFAULT_PRECISION = 4;
    localparam int DEFAULT_ACT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        WAIT_DONE = 2'd2
    } ser_state_t;

endpackage

// File: rtl/piso_shift.sv
// rtl/piso_shift.sv - loadable parallel-in/serial-out register, MSB first
module piso_shift #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    // Zeros shift in from the bottom so an emptied register drives msb low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end else if (clear) begin
            q <= '0;
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/weight_bit_serializer.sv
// rtl/weight_bit_serializer.sv - streams (act, weight) pairs bit-serially into the fp_int_mac weight port
module weight_bit_serializer
    import fp_int_mac_pkg::*;
#(
    parameter int PRECISION = DEFAULT_PRECISION,
    parameter int ACT_WIDTH = DEFAULT_ACT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ACT_WIDTH-1:0] in_act,
    input  logic [PRECISION-1:0] in_w,
    input  logic                 in_last,
    output logic                 mac_valid,
    output logic [ACT_WIDTH-1:0] mac_act,
    output logic                 mac_w,
    input  logic                 mac_done,
    output logic                 frame_done,
    output logic                 underrun
);

    localparam int CW = $clog2(PRECISION);
    localparam logic [CW-1:0] LSB_CNT = CW'(PRECISION - 1);

    ser_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [PRECISION-1:0] hd_w, hd_w_nx;
    logic [ACT_WIDTH-1:0] hd_act, hd_act_nx, act_nx;
    logic hd_last, hd_last_nx, hd_valid, hd_valid_nx;
    logic sh_last, sh_last_nx, last_seen, last_seen_nx;
    logic underrun_nx, frame_done_nx, mac_valid_nx, in_ready_nx;
    logic sh_load, sh_shift, sh_clear;
    logic [PRECISION-1:0] sh_d;
    logic accept, lsb;

    assign accept = in_valid && in_ready;
    assign lsb    = (cnt == LSB_CNT);

    piso_shift #(.WIDTH(PRECISION)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .clear (sh_clear),
        .d     (sh_d),
        .msb   (mac_w)
    );

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        hd_w_nx       = hd_w;
        hd_act_nx     = hd_act;
        hd_last_nx    = hd_last;
        hd_valid_nx   = hd_valid;
        sh_last_nx    = sh_last;
        act_nx        = mac_act;
        last_seen_nx  = last_seen | (accept & in_last);
        underrun_nx   = underrun;
        frame_done_nx = 1'b0;
        sh_load       = 1'b0;
        sh_shift      = 1'b0;
        sh_clear      = 1'b0;
        sh_d          = in_w;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    sh_load    = 1'b1;
                    act_nx     = in_act;
                    sh_last_nx = in_last;
                    cnt_nx     = '0;
                    state_nx   = SHIFT;
                end
            end
            SHIFT: begin
                if (!lsb) begin
                    sh_shift = 1'b1;
                    cnt_nx   = cnt + CW'(1);
                    if (accept) begin
                        hd_w_nx     = in_w;
                        hd_act_nx   = in_act;
                        hd_last_nx  = in_last;
                        hd_valid_nx = 1'b1;
                    end
                end else begin
                    // LSB cycle: refill from the hold, else straight from the input, else drain
                    cnt_nx = '0;
                    if (hd_valid) begin
                        sh_load     = 1'b1;
                        sh_d        = hd_w;
                        act_nx      = hd_act;
                        sh_last_nx  = hd_last;
                        hd_valid_nx = 1'b0;
                    end else if (accept) begin
                        sh_load    = 1'b1;
                        act_nx     = in_act;
                        sh_last_nx = in_last;
                    end else if (sh_last) begin
                        sh_clear = 1'b1;
                        state_nx = WAIT_DONE;
                    end else begin
                        sh_clear    = 1'b1;
                        underrun_nx = 1'b1;
                        state_nx    = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (mac_done) begin
                    frame_done_nx = 1'b1;
                    last_seen_nx  = 1'b0;
                    state_nx      = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        mac_valid_nx = (state_nx == SHIFT);
        in_ready_nx  = !hd_valid_nx && (state_nx != WAIT_DONE) && !last_seen_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hd_w       <= '0;
            hd_act     <= '0;
            hd_last    <= 1'b0;
            hd_valid   <= 1'b0;
            sh_last    <= 1'b0;
            last_seen  <= 1'b0;
            mac_act    <= '0;
            mac_valid  <= 1'b0;
            in_ready   <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            hd_w       <= hd_w_nx;
            hd_act     <= hd_act_nx;
            hd_last    <= hd_last_nx;
            hd_valid   <= hd_valid_nx;
            sh_last    <= sh_last_nx;
            last_seen  <= last_seen_nx;
            mac_act    <= act_nx;
            mac_valid  <= mac_valid_nx;
            in_ready   <= in_ready_nx;
            frame_done <= frame_done_nx;
            underrun   <= underrun_nx;
        end
    end

endmodule

// File: tb/tb_weight_bit_serializer.sv
// tb/tb_weight_bit_serializer.sv - self-checking bench for weight_bit_serializer
module tb_weight_bit_serializer;
    import fp_int_mac_pkg::*;

    localparam int P = DEFAULT_PRECISION;
    localparam int A = DEFAULT_ACT_WIDTH;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [A-1:0] in_act = '0;
    logic [P-1:0] in_w = '0;
    logic         in_last = 1'b0;
    logic         mac_valid;
    logic [A-1:0] mac_act;
    logic         mac_w;
    logic         mac_done = 1'b0;
    logic         frame_done;
    logic         underrun;

    weight_bit_serializer #(.PRECISION(P), .ACT_WIDTH(A)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_act     (in_act),
        .in_w       (in_w),
        .in_last    (in_last),
        .mac_valid  (mac_valid),
        .mac_act    (mac_act),
        .mac_w      (mac_w),
        .mac_done   (mac_done),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [A-1:0] act; logic w; } beat_t;
    typedef struct { logic [A-1:0] act; logic [P-1:0] w; } pair_t;

    beat_t cap_q[$];
    int cyc = 0;
    int fd_count = 0;
    int exp_fd = 0;
    int inv_bad = 0;
    int n_checks = 0;
    int n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (mac_valid) cap_q.push_back(beat_t'{cyc, mac_act, mac_w});
            else if (mac_w !== 1'b0) inv_bad++;
            if (frame_done) fd_count++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [A-1:0] act, input logic [P-1:0] w, input logic last,
                        output int acc);
        in_valid = 1'b1;
        in_act   = act;
        in_w     = w;
        in_last  = last;
        acc      = -1;
        for (int i = 0; i < 100 && acc < 0; i++) begin
            if (in_ready) acc = cyc + 1;
            tick();
        end
        in_valid = 1'b0;
        if (acc < 0) check("accept_timeout", 0, 1);
    endtask

    task automatic close_frame(input int delay, input string tag);
        int waited = 0;
        while (mac_valid && waited < 200) begin
            tick();
            waited++;
        end
        repeat (delay) tick();
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        exp_fd++;
        check({tag, "_frame_done"}, frame_done, 1);
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        check({tag, "_frame_done_pulse"}, frame_done, 0);
    endtask

    // Reference: every pair expands into P beats, MSB first, act held, one beat per cycle
    task automatic check_stream(input string tag, input pair_t pairs[$], input int first_cyc);
        int k = 0;
        check({tag, "_len"}, cap_q.size(), pairs.size() * P);
        foreach (pairs[p]) begin
            for (int b = P - 1; b >= 0; b--) begin
                if (k < cap_q.size()) begin
                    check({tag, "_w"}, cap_q[k].w, pairs[p].w[b]);
                    check({tag, "_act"}, cap_q[k].act, pairs[p].act);
                    check({tag, "_cyc"}, cap_q[k].cyc, first_cyc + k);
                end
                k++;
            end
        end
    endtask

    task automatic run_frame(input pair_t pl[$], input int delay, input string tag);
        int acc0 = -1;
        int acc;
        cap_q.delete();
        foreach (pl[i]) begin
            send(pl[i].act, pl[i].w, (i == pl.size() - 1), acc);
            if (i == 0) acc0 = acc;
        end
        close_frame(delay, tag);
        check_stream(tag, pl, acc0);
    endtask

    initial begin
        pair_t pl[$];
        pair_t pa, pb;
        int acc, acc2, fd0, hits;

        #1 rst = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_mac_valid", mac_valid, 0);
        check("rst_mac_act", mac_act, 0);
        check("rst_mac_w", mac_w, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_underrun", underrun, 0);
        rst = 1'b0;
        tick();
        check("release_in_ready", in_ready, 1);
        check("release_mac_valid", mac_valid, 0);

        pl = '{pair_t'{16'h4569, 4'b0101}};
        run_frame(pl, 3, "single");

        pl = '{pair_t'{16'h4569, 4'b0101}, pair_t'{16'h2C1F, 4'b0011}, pair_t'{16'h4821, 4'b1100}};
        run_frame(pl, 0, "b2b");
        check("b2b_underrun", underrun, 0);

        pl = '{pair_t'{16'h4AAA, 4'b1010}};
        run_frame(pl, 1, "negw");

        for (int f = 0; f < 6; f++) begin
            int n = $urandom_range(1, 4);
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(pair_t'{A'($urandom), P'($urandom)});
            run_frame(pl, $urandom_range(0, 3), "rand");
        end
        check("rand_underrun", underrun, 0);

        // Backpressure through WAIT_DONE, with a stray mac_done during SHIFT
        pa = pair_t'{16'h3C00, 4'b0111};
        pb = pair_t'{16'h5A5A, 4'b1001};
        cap_q.delete();
        fd0 = fd_count;
        send(pa.act, pa.w, 1'b1, acc);
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        in_valid = 1'b1;
        in_act   = pb.act;
        in_w     = pb.w;
        in_last  = 1'b1;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            if (in_ready) hits++;
            tick();
        end
        check("bp_in_ready_low", hits, 0);
        check("bp_shift_done_ignored", fd_count - fd0, 0);
        pl = '{pa};
        check_stream("bp_a", pl, acc);
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        exp_fd++;
        check("bp_frame_done", frame_done, 1);
        check("bp_in_ready_after", in_ready, 1);
        acc = cyc + 1;
        cap_q.delete();
        tick();
        in_valid = 1'b0;
        close_frame(1, "bp_b");
        pl = '{pb};
        check_stream("bp_b", pl, acc);

        // mac_done already high on the first WAIT_DONE cycle: next MSB at LSB+3
        pa = pair_t'{16'h1234, 4'b1110};
        pb = pair_t'{16'h7BCD, 4'b1011};
        cap_q.delete();
        mac_done = 1'b1;
        send(pa.act, pa.w, 1'b1, acc);
        in_valid = 1'b1;
        in_act   = pb.act;
        in_w     = pb.w;
        in_last  = 1'b1;
        acc2 = -1;
        for (int i = 0; i < 20 && acc2 < 0; i++) begin
            if (in_ready) acc2 = cyc + 1;
            tick();
        end
        in_valid = 1'b0;
        mac_done = 1'b0;
        exp_fd++;
        close_frame(0, "lsb3");
        check("lsb3_len", cap_q.size(), 2 * P);
        if (cap_q.size() == 2 * P) begin
            check("lsb3_gap", cap_q[P].cyc - cap_q[P-1].cyc, 3);
            check("lsb3_msb", cap_q[P].w, pb.w[P-1]);
            check("lsb3_act", cap_q[P].act, pb.act);
        end

        // Underrun: non-last pair followed by a 6-cycle bubble
        pa = pair_t'{A'($urandom), P'($urandom)};
        cap_q.delete();
        send(pa.act, pa.w, 1'b0, acc);
        repeat (6) tick();
        check("ur_flag", underrun, 1);
        check("ur_mac_valid", mac_valid, 0);
        pl = '{pa};
        check_stream("ur_first", pl, acc);
        pl = '{pair_t'{A'($urandom), P'($urandom)}};
        run_frame(pl, 2, "ur_resume");
        check("ur_sticky", underrun, 1);

        // Reset at the second bit of a pair with the hold full
        pa = pair_t'{16'h6E6E, 4'b1101};
        pb = pair_t'{16'h0F0F, 4'b0110};
        send(pa.act, pa.w, 1'b0, acc);
        send(pb.act, pb.w, 1'b1, acc2);
        rst = 1'b1;
        #1;
        check("mid_rst_mac_valid", mac_valid, 0);
        check("mid_rst_mac_w", mac_w, 0);
        check("mid_rst_mac_act", mac_act, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_underrun", underrun, 0);
        tick();
        tick();
        rst = 1'b0;
        cap_q.delete();
        fd0 = fd_count;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        repeat (8) tick();
        check("post_rst_no_bits", cap_q.size(), 0);
        check("post_rst_no_frame_done", fd_count - fd0, 0);
        check("post_rst_mac_valid", mac_valid, 0);

        check("total_frame_done", fd_count, exp_fd);
        check("idle_mac_w_zero", inv_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/weight_bit_serializer.md
# weight_bit_serializer

Transmit-side driver for the bit-serial `fp_int_mac` weight port. It accepts (FP16 activation, INT weight) pairs over a parallel ready/valid stream and drives the MAC's `valid`, `act` and `w` inputs. Each weight is sent MSB-first, one bit per clock, with `act` held stable for the whole weight. A frame (one dot product) is closed by dropping `mac_valid` after the last pair, then waiting for the MAC's `done` before the next frame is accepted.

## Interface
- `PRECISION`, 4: weight width in bits, two's complement; also the serial cycles per pair.
- `ACT_WIDTH`, 16: activation width, FP16.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-high.
- `in_valid` in 1: upstream pair valid.
- `in_ready` out 1: serializer can accept a pair this cycle.
- `in_act` in ACT_WIDTH: activation for the pair.
- `in_w` in PRECISION: weight for the pair.
- `in_last` in 1: pair is the final one of the frame.
- `mac_valid` out 1: drives MAC `valid`.
- `mac_act` out ACT_WIDTH: drives MAC `act`.
- `mac_w` out 1: drives MAC `w`.
- `mac_done` in 1: MAC `done`.
- `frame_done` out 1: one-cycle pulse when a frame completes.
- `underrun` out 1: sticky; set when a bubble is inserted mid-frame.

## Operation
- Storage:
  - shift register `sh_w[PRECISION-1:0]`, `sh_act`, `sh_last`;
  - one holding register `hd_w`, `hd_act`, `hd_last`, `hd_valid`;
  - bit counter of `$clog2(PRECISION)` bits.
- States:
  - IDLE: shift register empty; `mac_valid`=0.
  - SHIFT: a pair is being sent.
  - WAIT_DONE: last pair fully sent; waiting for `mac_done`.
- Accept: a pair is accepted when `in_valid && in_ready`. The rule for `in_ready`:
  - `in_ready` = !`hd_valid` && state!=WAIT_DONE && no `in_last` pair already accepted in the current frame.
  - The rule is registered-state only; there is no combinational path from `in_valid` to `in_ready`.
- IDLE→SHIFT on accept:
  - the pair loads straight into the shift register;
  - the counter is cleared.
- SHIFT behaviour:
  - `mac_w` = `sh_w[PRECISION-1]` and the register shifts left each cycle.
  - `mac_act` = `sh_act`; `mac_valid` = 1.
  - An accept during SHIFT goes to the holding register.
- On the LSB cycle (counter = PRECISION-1):
  - `hd_valid`: the hold contents move to the shift register next cycle. This is back-to-back, with no `mac_valid` gap.
  - else if `sh_last`: go to WAIT_DONE; `mac_valid`=0 next cycle.
  - else (underrun): go to IDLE, set `underrun`, `mac_valid`=0.
- Same-cycle case: an accept arriving in the LSB cycle while the hold is empty loads the shift register directly. The MSB is then sent the next cycle with no bubble, and this is not an underrun.
- WAIT_DONE→IDLE on `mac_done`=1, pulsing `frame_done` in that cycle. `mac_done` in IDLE or SHIFT is ignored.
- `mac_act` holds its last value whenever `mac_valid`=0. `mac_w` is 0 whenever `mac_valid`=0.
- `underrun` is cleared only by `rst`.

## Timing
- Reset values: `in_ready`=0 while `rst` is high, and 1 in the first cycle after release. `mac_valid`=0, `mac_act`=0, `mac_w`=0, `frame_done`=0, `underrun`=0. State is IDLE, `hd_valid`=0, counter=0.
- Latency: for an accept at edge t, the MSB appears on `mac_w` in cycle t+1 and the LSB in cycle t+PRECISION.
- Throughput: one pair per PRECISION cycles when upstream keeps the hold filled.
- After the last LSB, `mac_valid` is low for at least one cycle. If `mac_done` is already high in the first WAIT_DONE cycle, the earliest next-frame MSB is LSB+3.
- All outputs are registered.
- Reset mid-frame: all outputs clear asynchronously. Held and in-flight pairs are discarded and no `frame_done` pulse is issued.

## Structure
- Shared package `fp_int_mac_pkg`:
  - `PRECISION` and `ACT_WIDTH` defaults, shared with `fp_int_mac`;
  - the state enum (IDLE, SHIFT, WAIT_DONE).
- One natural sub-module: `piso_shift`, a loadable parallel-in/serial-out register of PRECISION bits with a load strobe and MSB output.

## Test plan
- Single pair: `in_act`=16'h4569, `in_w`=4'b0101, `in_last`=1 → `mac_w`=0,1,0,1 in cycles t+1..t+4. `mac_act`=16'h4569 and `mac_valid`=1 in those cycles, then `mac_valid`=0. Drive `mac_done` 3 cycles later → one `frame_done` pulse; `in_ready` returns high.
- Back-to-back frame of three pairs, 16'h4569/0101, 16'h2C1F/0011, 16'h4821/1100 (last), with `in_valid` held high → 12 consecutive `mac_valid`=1 cycles. `mac_w` stream is 010100111100. `mac_act` changes exactly every 4 cycles; `underrun` stays 0.
- Negative weight: 16'h4AAA/4'b1010 → `mac_w`=1,0,1,0.
- Underrun: first pair non-last, `in_valid` dropped for 6 cycles → `mac_valid` falls after the LSB and `underrun`=1 (sticky). The next pair resumes with its MSB first.
- Backpressure: `in_valid` held high during WAIT_DONE → `in_ready`=0 and no accept until the cycle after `frame_done`. `mac_done` pulses during SHIFT are ignored.
- Reset mid-frame: assert `rst` at the 2nd bit of a pair with the hold full → `mac_valid`/`mac_w`/`mac_act` read 0 while `rst` is high. After release: IDLE, `in_ready`=1, no `frame_done`, no stale bits emitted.
